// File: rtl/mdu_e_pkg.sv
// Shared CPU definitions: ALU/MDU operation codes, multiply/divide latencies
// and the HI/LO result payload.
package mdu_e_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned MDU_OP_W        = 3;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // ALU operation codes used by the E-stage ALU
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  // Multiply/divide unit operation codes; 6 and 7 are no-ops
  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_NOP6  = 3'd6,
    MDU_NOP7  = 3'd7
  } mdu_op_e;

  // HI/LO pair; HI occupies the upper half so a 64-bit product maps directly
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // True for the four multi-cycle operations (MULT, MULTU, DIV, DIVU)
  function automatic logic is_md_op(input logic [MDU_OP_W-1:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV with HI/LO registers
// and MTHI/MTLO writes; stall_req holds the pipeline while an op is in flight.
module mdu_e
  import mdu_e_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     A,
  input  logic [XLEN-1:0]     B,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] mdu_op,
  input  logic                mt_we,
  output logic [XLEN-1:0]     HI,
  output logic [XLEN-1:0]     LO,
  output logic                busy,
  output logic                stall_req
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] NEG_ONE = {XLEN{1'b1}};

  logic [XLEN-1:0]  hi_q, lo_q, a_q, b_q;
  mdu_op_e          op_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  hilo_t            res;
  logic             res_we;

  // Result of the latched operation; divide-by-zero suppresses the write
  always_comb begin
    res    = '{hi: hi_q, lo: lo_q};
    res_we = 1'b0;
    case (op_q)
      MDU_MULT: begin
        res    = {{XLEN{a_q[XLEN-1]}}, a_q} * {{XLEN{b_q[XLEN-1]}}, b_q};
        res_we = 1'b1;
      end
      MDU_MULTU: begin
        res    = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
        res_we = 1'b1;
      end
      MDU_DIV: begin
        if (b_q != '0) begin
          res_we = 1'b1;
          if (a_q == INT_MIN && b_q == NEG_ONE) begin
            res.lo = INT_MIN;
            res.hi = '0;
          end else begin
            res.lo = $signed(a_q) / $signed(b_q);
            res.hi = $signed(a_q) % $signed(b_q);
          end
        end
      end
      MDU_DIVU: begin
        if (b_q != '0) begin
          res_we = 1'b1;
          res.lo = a_q / b_q;
          res.hi = a_q % b_q;
        end
      end
      default: begin
        res_we = 1'b0;
      end
    endcase
  end

  // Issue, countdown, commit and MTHI/MTLO; start has priority over mt_we
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= MDU_MULT;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
        if (res_we) begin
          hi_q <= res.hi;
          lo_q <= res.lo;
        end
      end
    end else if (start) begin
      if (is_md_op(mdu_op)) begin
        a_q    <= A;
        b_q    <= B;
        op_q   <= mdu_op_e'(mdu_op);
        busy_q <= 1'b1;
        cnt_q  <= mdu_op[1] ? DIV_LOAD : MULT_LOAD;
      end
    end else if (mt_we) begin
      case (mdu_op)
        MDU_MTHI: hi_q <= A;
        MDU_MTLO: lo_q <= A;
        default:  ;
      endcase
    end
  end

  assign HI        = hi_q;
  assign LO        = lo_q;
  assign busy      = busy_q;
  assign stall_req = start | busy_q;

endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e: scoreboard of expected HI/LO/latency.
module tb_mdu_e;
  import mdu_e_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] A, B;
  logic        start;
  logic [2:0]  mdu_op;
  logic        mt_we;
  logic [31:0] HI, LO;
  logic        busy;
  logic        stall_req;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_hi, cur_lo;

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .start     (start),
    .mdu_op    (mdu_op),
    .mt_we     (mt_we),
    .HI        (HI),
    .LO        (LO),
    .busy      (busy),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Pulse start for one edge and push the expected outcome
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int ecyc,
                       input string name);
    exp_t e;
    @(negedge clk);
    A = a; B = b; mdu_op = op; start = 1'b1; mt_we = 1'b0;
    e.hi = ehi; e.lo = elo; e.cycles = ecyc; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles (bounded) while scrambling the operand inputs
  task automatic drain(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      A = $urandom; B = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    start = 1'b0; mt_we = 1'b0; A = '0; B = '0; mdu_op = '0;
    reset = 1'b0;
    #12;
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", HI, 32'h0); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", LO, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
    @(negedge clk);
    reset = 1'b1;
    cur_hi = '0; cur_lo = '0;
  endtask

  task automatic test_mult();
    logic [2:0]  ops[2] = '{MDU_MULT, MDU_MULTU};
    logic [31:0] as[2]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] bs[2]  = '{32'h0000_0003, 32'hFFFF_FFFF};
    logic [31:0] ehs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] els[2] = '{32'hFFFF_FFFA, 32'h0000_0001};
    int cyc;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], as[i], bs[i], ehs[i], els[i], 5, (i == 0) ? "mult" : "multu");
      checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL mult_stall: got %b expected 1", stall_req); end
      drain(cyc);
      e = sb.pop_front();
      checks++; if (cyc !== e.cycles) begin errors++; $display("FAIL %s_busy: got %0d cycles expected %0d", e.name, cyc, e.cycles); end
      checks++; if (HI !== e.hi) begin errors++; $display("FAIL %s_hi: got %h expected %h", e.name, HI, e.hi); end
      checks++; if (LO !== e.lo) begin errors++; $display("FAIL %s_lo: got %h expected %h", e.name, LO, e.lo); end
      cur_hi = e.hi; cur_lo = e.lo;
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops[4] = '{MDU_DIV, MDU_DIV, MDU_DIV, MDU_DIVU};
    logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs[4]  = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0010};
    logic [31:0] ehs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_000F};
    logic [31:0] els[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0FFF_FFFF};
    string       nms[4] = '{"div_neg", "div_negdiv", "div_ovf", "divu"};
    int cyc;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], ehs[i], els[i], 10, nms[i]);
      drain(cyc);
      e = sb.pop_front();
      checks++; if (cyc !== e.cycles) begin errors++; $display("FAIL %s_busy: got %0d cycles expected %0d", e.name, cyc, e.cycles); end
      checks++; if (HI !== e.hi) begin errors++; $display("FAIL %s_hi: got %h expected %h", e.name, HI, e.hi); end
      checks++; if (LO !== e.lo) begin errors++; $display("FAIL %s_lo: got %h expected %h", e.name, LO, e.lo); end
      cur_hi = e.hi; cur_lo = e.lo;
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue((i == 0) ? MDU_DIVU : MDU_DIV, 32'h0000_0007, 32'h0, cur_hi, cur_lo, 10,
            (i == 0) ? "divu_zero" : "div_zero");
      drain(cyc);
      e = sb.pop_front();
      checks++; if (cyc !== e.cycles) begin errors++; $display("FAIL %s_busy: got %0d cycles expected %0d", e.name, cyc, e.cycles); end
      checks++; if (HI !== e.hi) begin errors++; $display("FAIL %s_hi: got %h expected %h", e.name, HI, e.hi); end
      checks++; if (LO !== e.lo) begin errors++; $display("FAIL %s_lo: got %h expected %h", e.name, LO, e.lo); end
    end
  endtask

  task automatic test_mt();
    int cyc;
    exp_t e;
    @(negedge clk);
    A = 32'h1234_5678; mdu_op = MDU_MTHI; mt_we = 1'b1;
    @(negedge clk);
    mt_we = 1'b0;
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h expected %h", HI, 32'h1234_5678); end
    checks++; if (LO !== cur_lo) begin errors++; $display("FAIL mthi_lo: got %h expected %h", LO, cur_lo); end
    cur_hi = 32'h1234_5678;
    A = 32'h0BAD_F00D; mdu_op = MDU_MTLO; mt_we = 1'b1;
    @(negedge clk);
    mt_we = 1'b0;
    checks++; if (LO !== 32'h0BAD_F00D) begin errors++; $display("FAIL mtlo_lo: got %h expected %h", LO, 32'h0BAD_F00D); end
    checks++; if (HI !== cur_hi) begin errors++; $display("FAIL mtlo_hi: got %h expected %h", HI, cur_hi); end
    cur_lo = 32'h0BAD_F00D;
    // MTLO presented while a MULTU is in flight must be ignored
    issue(MDU_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 5, "multu_mtlo");
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 2) begin
        mt_we = 1'b1; mdu_op = MDU_MTLO; A = 32'hDEAD_BEEF;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL mtlo_busy_stall: got %b expected 1", stall_req); end
      end else begin
        mt_we = 1'b0;
      end
      @(negedge clk);
    end
    mt_we = 1'b0;
    e = sb.pop_front();
    checks++; if (cyc !== e.cycles) begin errors++; $display("FAIL %s_busy: got %0d cycles expected %0d", e.name, cyc, e.cycles); end
    checks++; if (LO !== e.lo) begin errors++; $display("FAIL %s_lo: got %h expected %h", e.name, LO, e.lo); end
    checks++; if (HI !== e.hi) begin errors++; $display("FAIL %s_hi: got %h expected %h", e.name, HI, e.hi); end
    cur_hi = e.hi; cur_lo = e.lo;
  endtask

  task automatic test_back_to_back();
    int cyc;
    exp_t e;
    issue(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10, "divu_ign");
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 3) begin
        start = 1'b1; mdu_op = MDU_MULT; A = 32'd5; B = 32'd5;
      end else begin
        start = 1'b0; A = $urandom; B = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++; if (cyc !== e.cycles) begin errors++; $display("FAIL %s_busy: got %0d cycles expected %0d", e.name, cyc, e.cycles); end
    checks++; if (HI !== e.hi) begin errors++; $display("FAIL %s_hi: got %h expected %h", e.name, HI, e.hi); end
    checks++; if (LO !== e.lo) begin errors++; $display("FAIL %s_lo: got %h expected %h", e.name, LO, e.lo); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start_busy: got %b expected 0", busy); end
    cur_hi = e.hi; cur_lo = e.lo;
  endtask

  task automatic test_noop();
    for (int op = 6; op < 8; op++) begin
      @(negedge clk);
      start = 1'b1; mdu_op = 3'(op); A = $urandom; B = $urandom;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noop%0d_busy: got %b expected 0", op, busy); end
      checks++; if ({HI, LO} !== {cur_hi, cur_lo}) begin errors++; $display("FAIL noop%0d_hilo: got %h expected %h", op, {HI, LO}, {cur_hi, cur_lo}); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int cyc;
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULT; A = 32'h0000_1000; B = 32'h0000_1000;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL rst_mid_hilo: got %h expected %h", {HI, LO}, 64'h0); end
    @(negedge clk);
    reset = 1'b1;
    cur_hi = '0; cur_lo = '0;
    repeat (8) @(negedge clk);
    checks++; if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL rst_late_write: got %h expected %h", {HI, LO}, 64'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_late_busy: got %b expected 0", busy); end
    // Start presented on the very first edge after release
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; start = 1'b1; mdu_op = MDU_MULT; A = 32'hFFFF_FFFD; B = 32'hFFFF_FFFC;
    e.hi = 32'h0; e.lo = 32'd12; e.cycles = 5; e.name = "mult_after_rst";
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_edge_busy: got %b expected 1", busy); end
    drain(cyc);
    e = sb.pop_front();
    checks++; if (cyc !== e.cycles) begin errors++; $display("FAIL %s_busy: got %0d cycles expected %0d", e.name, cyc, e.cycles); end
    checks++; if ({HI, LO} !== {e.hi, e.lo}) begin errors++; $display("FAIL %s_hilo: got %h expected %h", e.name, {HI, LO}, {e.hi, e.lo}); end
    cur_hi = e.hi; cur_lo = e.lo;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [63:0] p;
    int cyc;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom_range(32'hFFFF, 1);
      if (i % 2 == 0) begin
        p = 64'(a) * 64'(b);
        issue(MDU_MULTU, a, b, p[63:32], p[31:0], 5, "rand_multu");
      end else begin
        issue(MDU_DIVU, a, b, a % b, a / b, 10, "rand_divu");
      end
      drain(cyc);
      e = sb.pop_front();
      checks++; if (cyc !== e.cycles) begin errors++; $display("FAIL %s_busy: got %0d cycles expected %0d", e.name, cyc, e.cycles); end
      checks++; if ({HI, LO} !== {e.hi, e.lo}) begin errors++; $display("FAIL %s_hilo: got %h expected %h", e.name, {HI, LO}, {e.hi, e.lo}); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_mt();
    test_back_to_back();
    test_noop();
    test_reset_mid();
    test_random();
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_left: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
